prio_code_decoder: RTL

PRIO_CODE_DECODER -- requirements
Module: prio_code_decoder

---
 rtl/prio_code_decoder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/prio_code_decoder.sv
// prio_code_decoder: decodes a 2-bit priority code into value/mask/hit and queues it in a 2-entry FIFO.
// Latency 1 cycle into an empty FIFO; in_ready is registered (low only when full). Optional macro: PRIO_DEC_STATS_EN.
module prio_code_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_value,
  output logic [2:0]  out_mask,
  output logic        out_hit
`ifdef PRIO_DEC_STATS_EN
  ,
  output logic [15:0] cnt_hit,
  output logic [15:0] cnt_miss
`endif
);

  typedef struct packed {
    logic [2:0] value;
    logic [2:0] mask;
    logic       hit;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  entry_t head;
  entry_t tail;
  entry_t dec;
  logic   push;
  logic   pop;

  always_comb begin
    dec = '0;
    case (in_code)
      2'b11:   dec = '{value: 3'b100, mask: 3'b100, hit: 1'b1};
      2'b10:   dec = '{value: 3'b010, mask: 3'b110, hit: 1'b1};
      2'b01:   dec = '{value: 3'b001, mask: 3'b111, hit: 1'b1};
      default: dec = '{value: 3'b000, mask: 3'b111, hit: 1'b0};
    endcase
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign out_value = head.value;
  assign out_mask  = head.mask;
  assign out_hit   = head.hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      head      <= '0;
      tail      <= '0;
    end else begin
      in_ready <= 1'b1;
      case (state)
        EMPTY: begin
          if (push) begin
            head      <= dec;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              tail     <= dec;
              in_ready <= 1'b0;
              state    <= FULL;
            end
            2'b01: begin
              // head is cleared so idle outputs read as zero
              head      <= '0;
              out_valid <= 1'b0;
              state     <= EMPTY;
            end
            2'b11:   head <= dec;
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            head  <= tail;
            tail  <= '0;
            state <= ONE;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          head      <= '0;
          out_valid <= 1'b0;
          state     <= EMPTY;
        end
      endcase
    end
  end

`ifdef PRIO_DEC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_hit  <= '0;
      cnt_miss <= '0;
    end else if (pop) begin
      if (head.hit) begin
        if (cnt_hit != 16'hFFFF) cnt_hit <= cnt_hit + 16'd1;
      end else begin
        if (cnt_miss != 16'hFFFF) cnt_miss <= cnt_miss + 16'd1;
      end
    end
  end
`endif

endmodule
